serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial sequencer that feeds the team's single-bit full-adder cell and consumes its outputs.
//  - Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
//  - Presents one bit pair per cycle, LSB first, together with the registered carry, to an external full adder.
//  - Captures the adder's sum/carry each cycle and returns the WIDTH-bit result and carry-out over a valid/ready handshake.
//  - Sits between operand source and result sink; trades WIDTH cycles of latency for a single adder cell.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      operand handshake: a, b, cin valid
//  in_ready   out  1      operand handshake: block can accept
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry into bit 0
//  fa_x1      out  1      to full adder: current bit of A
//  fa_x2      out  1      to full adder: current bit of B
//  fa_cin     out  1      to full adder: registered carry
//  fa_sum     in   1      from full adder: sum bit (combinational from fa_*)
//  fa_cout    in   1      from full adder: carry out
//  out_valid  out  1      result handshake: sum, cout valid
//  out_ready  in   1      result handshake: sink accepts
//  sum        out  WIDTH  result bits
//  cout       out  1      final carry out
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain.
//  - rst_n low (any time, asynchronous): state=IDLE; all shift regs, carry_q and bit counter cleared.
//  - Reset values: in_ready=1, out_valid=0, sum=0, cout=0, fa_x1=fa_x2=fa_cin=0.
//  - Reset mid-RUN or mid-DONE discards the operation; no partial result is ever presented.
//  FSM states: IDLE, RUN, DONE
//  - IDLE: in_ready=1, out_valid=0, fa_* = 0.
//    - in_valid=1 at edge: a_sh<=a, b_sh<=b, carry_q<=cin, cnt<=0, state->RUN.
//  - RUN: in_ready=0, out_valid=0.
//    - fa_x1=a_sh[0], fa_x2=b_sh[0], fa_cin=carry_q.
//    - Each edge: a_sh, b_sh shift right; sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}; carry_q<=fa_cout; cnt<=cnt+1.
//    - Edge where cnt==WIDTH-1 (last bit captured): state->DONE.
//  - DONE: out_valid=1, sum=sum_sh, cout=carry_q, fa_* = 0, in_ready=0.
//    - sum and cout are held stable while out_ready=0 (no limit on stall length).
//    - out_ready=1 at edge: state->IDLE.
//  Handshake and latency
//  - Operand accept edge = edge with in_valid & in_ready.
//  - out_valid rises exactly WIDTH edges after the accept edge.
//  - in_ready returns 1 the cycle after the result handshake completes.
//  - No new operand is accepted in the same edge as the result handshake.
//  - Throughput: WIDTH+2 cycles per operation with out_ready tied high.
//  Arithmetic and boundaries
//  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
//  - cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1 within RUN.
//  - in_valid is ignored outside IDLE; a, b, cin are sampled only on the accept edge.
//  - fa_sum and fa_cout are sampled only in RUN.
// TESTING (WIDTH=8 unless noted)
//  1 a=8'hFF, b=8'h01, cin=0 -> 8 edges after accept: out_valid=1, sum=8'h00, cout=1.
//  2 a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0; fa_x1/fa_x2 sequence = 0,1,0,1,1,0,1,0 / 0,0,1,1,1,1,0,0.
//  3 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0, in_valid pulses ignored.
//  4 Reset: assert rst_n=0 at RUN cnt=3, release, send a=8'h10, b=8'h20, cin=0 -> sum=8'h30, cout=0, no stale output.
//  5 Back-to-back with out_ready=1 and in_valid=1: accepts every 10 cycles.
//    - Randomised 1000-vector compare against a+b+cin, WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial sequencer around an external single-bit full adder.
// Operands arrive over a valid/ready handshake.
// One bit pair per cycle is presented LSB first, together with the registered carry.
// The adder's sum/carry are captured each cycle.
// The WIDTH-bit result plus carry-out is returned over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one bit per cycle through the external adder, cnt_q = bit index
// DONE  | result presented on sum/cout, held until out_ready
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_x1,
  output logic             fa_x2,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             run_q;

  // Sequencer: operand capture, per-bit shifting through the adder, result hold.
  // The counter stops at the last bit index instead of wrapping, so it only
  // ever holds values 0..WIDTH-1 while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            carry_q    <= cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            run_q      <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= {fa_sum, sum_sh_q[WIDTH-1:1]};
          carry_q  <= fa_cout;
          if (cnt_q == CNT_LAST) begin
            run_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE here, not accepting, keeps a new operand out
          // of the result handshake edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          run_q       <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Adder inputs are forced to zero outside RUN.
  // Results are masked to zero outside DONE, so nothing partial ever appears on sum/cout.
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign fa_x1     = run_q & a_sh_q[0];
  assign fa_x2     = run_q & b_sh_q[0];
  assign fa_cin    = run_q & carry_q;
  assign sum       = {WIDTH{out_valid_q}} & sum_sh_q;
  assign cout      = out_valid_q & carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: WIDTH=8 and WIDTH=16 instances, each with
// a behavioural full adder, checked against plain a+b+cin arithmetic.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv;
  logic        ordy;
  logic        cin_t;
  logic        sel16;
  logic [15:0] a_t;
  logic [15:0] b_t;

  logic        in_ready8, out_valid8, cout8, x1_8, x2_8, fcin8, fsum8, fcout8;
  logic [7:0]  sum8;
  logic        in_ready16, out_valid16, cout16, x1_16, x2_16, fcin16, fsum16, fcout16;
  logic [15:0] sum16;

  // Behavioural full adder cells
  assign fsum8   = x1_8 ^ x2_8 ^ fcin8;
  assign fcout8  = (x1_8 & x2_8) | (fcin8 & (x1_8 ^ x2_8));
  assign fsum16  = x1_16 ^ x2_16 ^ fcin16;
  assign fcout16 = (x1_16 & x2_16) | (fcin16 & (x1_16 ^ x2_16));

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv & ~sel16), .in_ready(in_ready8),
    .a(a_t[7:0]), .b(b_t[7:0]), .cin(cin_t),
    .fa_x1(x1_8), .fa_x2(x2_8), .fa_cin(fcin8),
    .fa_sum(fsum8), .fa_cout(fcout8),
    .out_valid(out_valid8), .out_ready(ordy & ~sel16),
    .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv & sel16), .in_ready(in_ready16),
    .a(a_t), .b(b_t), .cin(cin_t),
    .fa_x1(x1_16), .fa_x2(x2_16), .fa_cin(fcin16),
    .fa_sum(fsum16), .fa_cout(fcout16),
    .out_valid(out_valid16), .out_ready(ordy & sel16),
    .sum(sum16), .cout(cout16)
  );

  logic        m_ready, m_valid, m_cout, m_x1, m_x2, m_fcin;
  logic [15:0] m_sum;
  assign m_ready = sel16 ? in_ready16  : in_ready8;
  assign m_valid = sel16 ? out_valid16 : out_valid8;
  assign m_cout  = sel16 ? cout16      : cout8;
  assign m_x1    = sel16 ? x1_16       : x1_8;
  assign m_x2    = sel16 ? x2_16       : x2_8;
  assign m_fcin  = sel16 ? fcin16      : fcin8;
  assign m_sum   = sel16 ? sum16       : {8'h00, sum8};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Carry entering bit i of av+bv+cv, from plain integer addition of the low bits
  function automatic logic carry_into(input int unsigned av, input int unsigned bv,
                                      input int unsigned cv, input int i);
    int unsigned m;
    m = (32'd1 << i) - 32'd1;
    return 1'(((av & m) + (bv & m) + cv) >> i);
  endfunction

  function automatic int unsigned width_now();
    return sel16 ? 16 : 8;
  endfunction

  // One full operation on the selected DUT: accept, per-bit adder traffic,
  // latency, result, optional backpressure with ignored in_valid pulses, release.
  task automatic op(input logic [15:0] av_in, input logic [15:0] bv_in, input logic cv,
                    input int stall, input bit pulse);
    int unsigned w, m, s, av, bv;
    logic [15:0] hold_sum;
    logic        hold_cout;
    int          guard;
    w  = width_now();
    m  = (32'd1 << w) - 32'd1;
    av = 32'(av_in) & m;
    bv = 32'(bv_in) & m;
    s  = av + bv + 32'(cv);
    @(negedge clk);
    chk("ready_before_accept", 32'(m_ready), 32'd1);
    a_t = av_in; b_t = bv_in; cin_t = cv; iv = 1'b1; ordy = 1'b0;
    @(posedge clk); #1;
    iv = 1'b0;
    a_t = 16'($urandom); b_t = 16'($urandom); cin_t = 1'($urandom_range(0, 1));
    for (int i = 0; i < int'(w); i++) begin
      chk("run_ready", 32'(m_ready), 32'd0);
      chk("run_valid", 32'(m_valid), 32'd0);
      chk("fa_x1",  32'(m_x1),   32'((av >> i) & 1));
      chk("fa_x2",  32'(m_x2),   32'((bv >> i) & 1));
      chk("fa_cin", 32'(m_fcin), 32'(carry_into(av, bv, 32'(cv), i)));
      @(posedge clk); #1;
    end
    chk("latency_valid", 32'(m_valid), 32'd1);
    guard = 0;
    while (!m_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!m_valid) begin
      n_cmp++; n_err++;
      $display("FAIL valid_timeout: observed 0 expected 1");
    end
    chk("sum",  32'(m_sum),  s & m);
    chk("cout", 32'(m_cout), (s >> w) & 32'd1);
    chk("done_fa", 32'({m_x1, m_x2, m_fcin}), 32'd0);
    hold_sum  = m_sum;
    hold_cout = m_cout;
    for (int k = 0; k < stall; k++) begin
      if (pulse) begin
        iv = 1'b1; a_t = 16'($urandom); b_t = 16'($urandom);
      end
      @(posedge clk); #1;
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_ready", 32'(m_ready), 32'd0);
      chk("stall_sum",   32'(m_sum),   32'(hold_sum));
      chk("stall_cout",  32'(m_cout),  32'(hold_cout));
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("post_hs_valid", 32'(m_valid), 32'd0);
    chk("post_hs_ready", 32'(m_ready), 32'd1);
    chk("post_hs_sum",   32'(m_sum),   32'd0);
  endtask

  initial begin
    int unsigned s;
    int          cyc, last, nacc, guard;
    logic [16:0] q[$];
    logic [16:0] e;

    rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; cin_t = 1'b0; sel16 = 1'b0;
    a_t = '0; b_t = '0;
    #12;
    // Reset values on both widths
    chk("rst_ready8",  32'(in_ready8),  32'd1);
    chk("rst_valid8",  32'(out_valid8), 32'd0);
    chk("rst_sum8",    32'(sum8),       32'd0);
    chk("rst_cout8",   32'(cout8),      32'd0);
    chk("rst_fa8",     32'({x1_8, x2_8, fcin8}), 32'd0);
    chk("rst_ready16", 32'(in_ready16), 32'd1);
    chk("rst_valid16", 32'(out_valid16), 32'd0);
    chk("rst_sum16",   32'(sum16),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases on WIDTH=8
    op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    op(16'h005A, 16'h003C, 1'b1, 0, 1'b0);
    op(16'h00C3, 16'h00A5, 1'b1, 5, 1'b1);
    op(16'h0000, 16'h0000, 1'b0, 1, 1'b0);
    op(16'h00FF, 16'h00FF, 1'b1, 0, 1'b0);

    // Reset at RUN bit 3, then a clean operation
    @(negedge clk);
    a_t = 16'h00FF; b_t = 16'h00FF; cin_t = 1'b1; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", 32'(in_ready8),  32'd1);
    chk("midrun_rst_valid", 32'(out_valid8), 32'd0);
    chk("midrun_rst_fa",    32'({x1_8, x2_8, fcin8}), 32'd0);
    chk("midrun_rst_sum",   32'({cout8, sum8}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(16'h0010, 16'h0020, 1'b0, 0, 1'b0);

    // Back-to-back with in_valid and out_ready held high: accepts every 10 cycles
    @(negedge clk);
    iv = 1'b1; ordy = 1'b1;
    cyc = 0; last = -1; nacc = 0;
    while (nacc < 4 && cyc < 80) begin
      a_t = 16'($urandom); b_t = 16'($urandom); cin_t = 1'($urandom_range(0, 1));
      if (m_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b_sum", 32'({m_cout, m_sum[7:0]}), 32'(e));
        end else begin
          n_cmp++; n_err++;
          $display("FAIL b2b_unexpected_result: observed valid expected none");
        end
      end
      if (m_ready) begin
        if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 32'd10);
        last = cyc;
        nacc++;
        s = 32'(a_t[7:0]) + 32'(b_t[7:0]) + 32'(cin_t);
        q.push_back(17'(s));
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_accepts", 32'(nacc), 32'd4);
    iv = 1'b0;
    guard = 0;
    while (!m_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("b2b_last_valid", 32'(m_valid), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("b2b_last_sum", 32'({m_cout, m_sum[7:0]}), 32'(e));
    end
    @(negedge clk);
    ordy = 1'b0;
    chk("b2b_idle_ready", 32'(m_ready), 32'd1);

    // Randomised vectors on WIDTH=8 then WIDTH=16
    for (int n = 0; n < 1000; n++)
      op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    sel16 = 1'b1;
    for (int n = 0; n < 1000; n++)
      op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
